program_loader: RTL and testbench
=================================

# program_loader

Front-end loader that fills the instruction memory of `InstructionFetch` before the pipeline runs. It collects bytes from the debug UART receiver, packs four bytes into a 32-bit instruction, and drives the fetch stage's `write_inst_mem` / `inst_mem_addr` / `inst_mem_data` port at consecutive addresses. Loading stops after the HALT word is written or the memory is full. `load_done` then becomes the fetch stage's `enable`.

## Interface

Parameters:
- `INST_WIDTH`, 32: instruction width; must be 4 × `BYTE_WIDTH`.
- `BYTE_WIDTH`, 8: UART byte width.
- `ADDR_WIDTH`, 8: instruction memory address width (word addressed).
- `HALT_INST`, 32'hFFFFFFFF: end-of-program word.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `load_start` in 1: single-cycle pulse that starts or restarts a load.
- `rx_data` in `BYTE_WIDTH`: received byte, valid when `rx_done`=1.
- `rx_done` in 1: single-cycle strobe, one per received byte.
- `write_inst_mem` out 1: instruction memory write strobe (one cycle per word).
- `inst_mem_addr` out `ADDR_WIDTH`: write address.
- `inst_mem_data` out `INST_WIDTH`: write data.
- `load_done` out 1: program loaded; drives fetch `enable`.
- `overflow` out 1: memory filled before HALT was received.
- `words_loaded` out `ADDR_WIDTH+1`: count of words written in the current load.

## Operation

- States: IDLE, RECV, WRITE, DONE.
- IDLE: wait for `load_start`; on `load_start` go to RECV with address=0, byte_cnt=0, `words_loaded`=0.
- RECV: each `rx_done` shifts in `rx_data`, big-endian.
  - Byte 0 lands in [31:24] and byte 3 in [7:0].
  - byte_cnt increments 0→3.
  - On the 4th byte (byte_cnt=3 with `rx_done`=1): byte_cnt wraps to 0 and the state moves to WRITE.
- WRITE (exactly one cycle):
  - `write_inst_mem`=1, `inst_mem_addr`=current address, `inst_mem_data`=assembled word.
  - Next cycle: `write_inst_mem`=0 and `words_loaded` increments.
  - If the word equals `HALT_INST`: go to DONE; the HALT word is written so fetch sees it.
  - Else if address = 2^ADDR_WIDTH−1: go to DONE and set `overflow`=1.
  - Otherwise the address increments and the state returns to RECV.
- `rx_done` during WRITE:
  - Normally the byte is captured as byte 0 of the next word (byte_cnt becomes 1); no byte is lost.
  - If WRITE is exiting to DONE, the byte is discarded.
- DONE: `load_done`=1 and is held.
  - `rx_done` is ignored.
  - `load_start` clears `load_done`, `overflow`, address, byte_cnt and `words_loaded`, then goes to RECV.
- `load_start` in RECV or WRITE is ignored; a load cannot be aborted except by `rst`.
- A partial word (fewer than 4 bytes) is never written.

## Timing

- All outputs are registered.
- Reset values: state=IDLE; `write_inst_mem`=0; `inst_mem_addr`=0; `inst_mem_data`=0; `load_done`=0; `overflow`=0; `words_loaded`=0; byte_cnt=0.
- Latency: the 4th-byte `rx_done` at edge N gives `write_inst_mem`=1 during cycle N+1. Address and data are stable for that whole cycle, so memory captures them at edge N+2.
- `load_done` rises the cycle after the final WRITE cycle (N+2 relative to the last `rx_done`).
- The 4-byte shift and address increment use fixed widths; the address never wraps, because the overflow check precedes the increment.
- `rst` asserted mid-load: everything returns to reset values immediately (asynchronously), with no further write strobe.
- Back-to-back `rx_done` on consecutive cycles is supported at any byte position.

## Test plan

- Reset, pulse `load_start`, send bytes 00 00 00 0A, 00 00 00 14, FF FF FF FF:
  - Writes addr0=0x0000000A, addr1=0x00000014, addr2=0xFFFFFFFF.
  - `load_done`=1 two cycles after the last byte; `words_loaded`=3; `overflow`=0.
- Byte ordering: send 12 34 56 78 then HALT → addr0 data=0x12345678.
- Strobe: `write_inst_mem` is high exactly one cycle per word.
- `rx_done` on consecutive cycles across a word boundary (byte 0 of word 2 arrives during WRITE of word 1): word 2 is assembled correctly with no dropped byte.
- Overflow (ADDR_WIDTH=2): send 4 non-HALT words → `overflow`=1, `load_done`=1, `words_loaded`=4, last write at addr 3, further `rx_done` ignored.
- Assert `rst` after 2 bytes of word 1: all outputs return to 0 immediately. A new `load_start` followed by a full program writes from addr 0.
- `load_start` in DONE: flags clear and reload starts at addr 0. `load_start` during RECV: ignored, byte_cnt preserved.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master side is the loader; the slave side feeds bytes and consumes writes.
interface program_loader_if #(
   parameter int BYTE_WIDTH = 8,
   parameter int INST_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                  load_start;
   logic [BYTE_WIDTH-1:0] rx_data;
   logic                  rx_done;
   logic                  write_inst_mem;
   logic [ADDR_WIDTH-1:0] inst_mem_addr;
   logic [INST_WIDTH-1:0] inst_mem_data;
   logic                  load_done;
   logic                  overflow;
   logic [ADDR_WIDTH:0]   words_loaded;

   modport master (
      input  load_start, rx_data, rx_done,
      output write_inst_mem, inst_mem_addr, inst_mem_data, load_done, overflow, words_loaded
   );

   modport slave (
      output load_start, rx_data, rx_done,
      input  write_inst_mem, inst_mem_addr, inst_mem_data, load_done, overflow, words_loaded
   );
endinterface

// File: rtl/program_loader.sv
// Packs UART bytes big-endian into instruction words and writes them to
// consecutive instruction-memory addresses until HALT or the memory is full.
module program_loader #(
   parameter int                    INST_WIDTH = 32,
   parameter int                    BYTE_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [INST_WIDTH-1:0] HALT_INST  = 32'hFFFF_FFFF
) (
   input logic              clk,
   input logic              rst,
   program_loader_if.master bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RECV  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_WIDTH:0]   WL_ONE   = 1;

   logic [1:0]            state;
   logic [1:0]            byte_cnt;
   logic [INST_WIDTH-1:0] shift_reg;
   logic [INST_WIDTH-1:0] assembled;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  write_q;
   logic [INST_WIDTH-1:0] data_q;
   logic                  done_q;
   logic                  overflow_q;
   logic [ADDR_WIDTH:0]   words_q;

   // Earlier bytes move toward the MSB, so byte 0 ends up in the top lane.
   assign assembled = {shift_reg[INST_WIDTH-BYTE_WIDTH-1:0], bus.rx_data};

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values of the others, and the reset branch is asynchronous.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         byte_cnt   <= '0;
         shift_reg  <= '0;
         addr       <= '0;
         write_q    <= 1'b0;
         data_q     <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         words_q    <= '0;
      end else begin
         write_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.load_start) begin
                  state      <= RECV;
                  addr       <= '0;
                  byte_cnt   <= '0;
                  words_q    <= '0;
                  done_q     <= 1'b0;
                  overflow_q <= 1'b0;
               end
            end
            RECV: begin
               if (bus.rx_done) begin
                  shift_reg <= assembled;
                  if (byte_cnt == 2'd3) begin
                     byte_cnt <= '0;
                     data_q   <= assembled;
                     write_q  <= 1'b1;
                     state    <= WRITE;
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end
            WRITE: begin
               words_q <= words_q + WL_ONE;
               if (data_q == HALT_INST) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end else if (addr == ADDR_MAX) begin
                  state      <= DONE;
                  done_q     <= 1'b1;
                  overflow_q <= 1'b1;
               end else begin
                  addr  <= addr + ADDR_ONE;
                  state <= RECV;
                  // A byte arriving during the write slot starts the next word.
                  if (bus.rx_done) begin
                     shift_reg <= assembled;
                     byte_cnt  <= 2'd1;
                  end
               end
            end
         endcase
      end
   end

   assign bus.write_inst_mem = write_q;
   assign bus.inst_mem_addr  = addr;
   assign bus.inst_mem_data  = data_q;
   assign bus.load_done      = done_q;
   assign bus.overflow       = overflow_q;
   assign bus.words_loaded   = words_q;
endmodule

// File: tb/tb_program_loader.sv
// Randomized and directed checks of program_loader against a byte-stream model
// that derives expected writes and flags from the list of bytes sent.
module tb_program_loader;
   localparam int          AW    = 2;
   localparam int          DEPTH = 1 << AW;
   localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   logic [7:0]    prog[$];
   logic [AW-1:0] wa_q[$];
   logic [31:0]   wd_q[$];

   always #5 clk = ~clk;

   program_loader_if #(.BYTE_WIDTH(8), .INST_WIDTH(32), .ADDR_WIDTH(AW)) bus ();

   program_loader #(.INST_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .HALT_INST(HALT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Every cycle with the strobe high is recorded as one memory write.
   always @(negedge clk) begin
      if (rst && bus.write_inst_mem) begin
         wa_q.push_back(bus.inst_mem_addr);
         wd_q.push_back(bus.inst_mem_data);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      wa_q.delete();
      wd_q.delete();
      prog.delete();
      bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      prog.push_back(b);
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      tick();
      bus.rx_done = 1'b0;
      bus.rx_data = 8'($urandom);
      repeat (gap) tick();
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], $urandom_range(0, max_gap));
   endtask

   // Expected writes: consecutive 4-byte groups, stopping after HALT or a full memory.
   task automatic check_result(input string tag);
      logic [31:0] exp_w[$];
      bit          halted;
      bit          exp_ovf;
      int          t;
      halted = 0;
      for (int i = 0; i + 3 < prog.size() && !halted && exp_w.size() < DEPTH; i += 4) begin
         exp_w.push_back({prog[i], prog[i+1], prog[i+2], prog[i+3]});
         if (exp_w[exp_w.size()-1] == HALT) halted = 1;
      end
      exp_ovf = !halted && (exp_w.size() == DEPTH);
      t = 0;
      while (!bus.load_done && t < 40) begin
         tick();
         t++;
      end
      repeat (3) tick();
      check({tag, ".done"}, 64'(bus.load_done), 64'(halted || exp_ovf));
      check({tag, ".ovf"}, 64'(bus.overflow), 64'(exp_ovf));
      check({tag, ".words"}, 64'(bus.words_loaded), 64'(exp_w.size()));
      check({tag, ".nwr"}, 64'(wa_q.size()), 64'(exp_w.size()));
      for (int i = 0; i < exp_w.size() && i < wa_q.size(); i++) begin
         check($sformatf("%s.addr%0d", tag, i), 64'(wa_q[i]), 64'(i));
         check($sformatf("%s.data%0d", tag, i), 64'(wd_q[i]), 64'(exp_w[i]));
      end
   endtask

   initial begin
      bus.load_start = 1'b0;
      bus.rx_done    = 1'b0;
      bus.rx_data    = '0;
      repeat (3) tick();
      check("rst.wr", 64'(bus.write_inst_mem), 64'd0);
      check("rst.addr", 64'(bus.inst_mem_addr), 64'd0);
      check("rst.data", 64'(bus.inst_mem_data), 64'd0);
      check("rst.done", 64'(bus.load_done), 64'd0);
      check("rst.ovf", 64'(bus.overflow), 64'd0);
      check("rst.words", 64'(bus.words_loaded), 64'd0);
      rst = 1'b1;
      tick();

      // Basic program with latency checks around the final HALT word.
      pulse_start();
      send_word(32'h0000_000A, 1);
      send_word(32'h0000_0014, 1);
      send_byte(8'hFF, 1);
      send_byte(8'hFF, 0);
      send_byte(8'hFF, 0);
      send_byte(8'hFF, 0);
      check("lat.wr", 64'(bus.write_inst_mem), 64'd1);
      check("lat.addr", 64'(bus.inst_mem_addr), 64'd2);
      check("lat.done_early", 64'(bus.load_done), 64'd0);
      tick();
      check("lat.wr_off", 64'(bus.write_inst_mem), 64'd0);
      check("lat.done", 64'(bus.load_done), 64'd1);
      check_result("basic");

      // Byte ordering, back-to-back across the word boundary.
      pulse_start();
      send_word(32'h1234_5678, 0);
      send_word(HALT, 0);
      check_result("order");

      // Overflow with trailing bytes that must be ignored.
      pulse_start();
      for (int i = 0; i < DEPTH; i++) send_word(32'hA0B0_C0D0 + 32'(i), 0);
      for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
      check_result("ovf");

      // Restart from DONE clears flags.
      pulse_start();
      check("restart.done", 64'(bus.load_done), 64'd0);
      check("restart.ovf", 64'(bus.overflow), 64'd0);
      check("restart.words", 64'(bus.words_loaded), 64'd0);

      // load_start during RECV is ignored and keeps the byte position.
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 0);
      bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
      send_byte(8'hEF, 0);
      send_byte(8'h01, 1);
      send_word(HALT, 1);
      check_result("midstart");

      // Asynchronous reset partway into the second word.
      pulse_start();
      send_word(32'h1122_3344, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      #3 rst = 1'b0;
      #1;
      check("arst.wr", 64'(bus.write_inst_mem), 64'd0);
      check("arst.addr", 64'(bus.inst_mem_addr), 64'd0);
      check("arst.data", 64'(bus.inst_mem_data), 64'd0);
      check("arst.words", 64'(bus.words_loaded), 64'd0);
      tick();
      rst = 1'b1;
      tick();
      pulse_start();
      send_word(32'hDEAD_BEEF, 1);
      send_word(HALT, 1);
      check_result("after_rst");

      // Random programs: random length, random HALT placement, random gaps.
      for (int r = 0; r < 15; r++) begin
         int nw;
         pulse_start();
         nw = $urandom_range(1, DEPTH + 1);
         for (int w = 0; w < nw; w++) begin
            logic [31:0] word;
            word = $urandom;
            if ($urandom_range(0, 3) == 0) word[31:24] = 8'hFF;
            if ($urandom_range(0, 7) == 0) word = HALT;
            if (w == nw - 1 && nw < DEPTH) word = HALT;
            send_word(word, 2);
         end
         for (int i = 0; i < int'($urandom_range(0, 5)); i++) send_byte(8'($urandom), $urandom_range(0, 1));
         check_result($sformatf("rnd%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
